// File: rtl/uart_boot_loader.sv
// UART boot loader: polls the UART RX register, parses a framed boot image and writes it to memory.
// Optional feature macro: BOOT_CHECKSUM_EN (trailing mod-256 payload checksum byte).
module uart_boot_loader #(
  parameter logic [7:0]  MAGIC       = 8'hA5,
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned MAX_LEN     = 32'h10000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] entry_o,
  output logic [31:0] u_adr_o,
  output logic [31:0] u_dat_o,
  output logic        u_we_o,
  output logic        u_stb_o,
  input  logic        u_ack_i,
  input  logic [31:0] u_dat_i,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_stb_o,
  input  logic        m_ack_i
);

  typedef enum logic [2:0] {StIdle, StGap, StPoll, StSample, StMemwr, StDone, StErr} state_e;
  typedef enum logic [2:0] {PhMagic, PhLen, PhAddr, PhPayload, PhChk} phase_e;

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [31:0] gap_q, gap_d;
  logic [31:0] timer_q, timer_d;
  logic [1:0]  fld_q, fld_d;
  logic [31:0] len_q, len_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  sel_q, sel_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] entry_q, entry_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  logic [7:0] rx_byte;
  logic [1:0] lane;
  logic       unused_dat;

  assign rx_byte    = u_dat_i[7:0];
  assign lane       = cnt_q[1:0];
  assign unused_dat = ^u_dat_i[31:9];

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    gap_d   = gap_q;
    timer_d = timer_q;
    fld_d   = fld_q;
    len_d   = len_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    data_d  = data_q;
    sel_d   = sel_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;
    entry_d = entry_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    // The RX silence timer only runs while polling, not while a memory write is pending.
    if ((state_q == StGap || state_q == StPoll || state_q == StSample) && TIMEOUT_CYC != 0) begin
      timer_d = timer_q + 32'd1;
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = 2'd0;
          phase_d = PhMagic;
          timer_d = '0;
          gap_d   = '0;
          fld_d   = '0;
          len_d   = '0;
          addr_d  = '0;
          cnt_d   = '0;
          word_d  = '0;
          data_d  = '0;
          sel_d   = '0;
`ifdef BOOT_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q >= POLL_GAP - 1) begin
          gap_d   = '0;
          state_d = StPoll;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      StPoll: begin
        if (u_ack_i) state_d = StSample;
      end
      StSample: begin
        if (!u_dat_i[8]) begin
          if (TIMEOUT_CYC != 0 && timer_q >= TIMEOUT_CYC) begin
            code_d  = 2'd2;
            state_d = StErr;
          end else begin
            state_d = StGap;
          end
        end else begin
          timer_d = '0;
          state_d = StGap;
          unique case (phase_q)
            PhMagic: begin
              if (rx_byte != MAGIC) begin
                code_d  = 2'd1;
                state_d = StErr;
              end else begin
                phase_d = PhLen;
              end
            end
            PhLen: begin
              len_d[{fld_q, 3'b000} +: 8] = rx_byte;
              fld_d = fld_q + 2'd1;
              if (fld_q == 2'd3) phase_d = PhAddr;
            end
            PhAddr: begin
              addr_d[{fld_q, 3'b000} +: 8] = rx_byte;
              fld_d = fld_q + 2'd1;
              if (fld_q == 2'd3) begin
                if (addr_d[1:0] != 2'b00 || len_q > MAX_LEN) begin
                  code_d  = 2'd0;
                  state_d = StErr;
                end else if (len_q == 32'd0) begin
`ifdef BOOT_CHECKSUM_EN
                  phase_d = PhChk;
`else
                  state_d = StDone;
`endif
                end else begin
                  phase_d = PhPayload;
                end
              end
            end
            PhPayload: begin
              data_d[{lane, 3'b000} +: 8] = rx_byte;
              sel_d[lane] = 1'b1;
              cnt_d = cnt_q + 32'd1;
`ifdef BOOT_CHECKSUM_EN
              sum_d = sum_q + rx_byte;
`endif
              if (lane == 2'd3 || cnt_d == len_q) state_d = StMemwr;
            end
            PhChk: begin
`ifdef BOOT_CHECKSUM_EN
              if (rx_byte == sum_q) begin
                state_d = StDone;
              end else begin
                code_d  = 2'd3;
                state_d = StErr;
              end
`else
              state_d = StDone;
`endif
            end
            default: state_d = StErr;
          endcase
        end
      end
      StMemwr: begin
        if (m_ack_i) begin
          data_d  = '0;
          sel_d   = '0;
          word_d  = word_q + 32'd1;
          state_d = StGap;
          if (cnt_q == len_q) begin
`ifdef BOOT_CHECKSUM_EN
            phase_d = PhChk;
`else
            state_d = StDone;
`endif
          end
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Sticky flags rise together with the terminal state so they line up with busy falling.
    if (state_d == StDone) begin
      done_d  = 1'b1;
      entry_d = addr_d;
    end
    if (state_d == StErr) err_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      phase_q <= PhMagic;
      gap_q   <= '0;
      timer_q <= '0;
      fld_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      entry_q <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      timer_q <= timer_d;
      fld_q   <= fld_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      entry_q <= entry_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign busy     = (state_q == StGap) || (state_q == StPoll) ||
                    (state_q == StSample) || (state_q == StMemwr);
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign entry_o  = entry_q;

  assign u_adr_o = '0;
  assign u_dat_o = '0;
  assign u_we_o  = 1'b0;
  assign u_stb_o = (state_q == StPoll);

  // Bus fields are gated so they read 0 outside an active write.
  assign m_stb_o = (state_q == StMemwr);
  assign m_we_o  = m_stb_o;
  assign m_adr_o = m_stb_o ? addr_q + (word_q << 2) : '0;
  assign m_dat_o = m_stb_o ? data_q : '0;
  assign m_sel_o = m_stb_o ? sel_q : '0;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: UART RX and memory slave models, write and completion
// monitors checking against hand-computed expectations queued by the stimulus.
module tb_uart_boot_loader;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  typedef struct packed {
    logic        ok;
    logic [1:0]  code;
    logic [31:0] entry;
  } end_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [31:0] entry_o, u_adr_o, u_dat_o, m_adr_o, m_dat_o;
  logic        u_we_o, u_stb_o, u_ack_i, m_we_o, m_stb_o;
  logic        m_ack_i;
  logic [31:0] u_dat_i;
  logic [3:0]  m_sel_o;

  wr_t        exp_wr[$];
  end_t       exp_end[$];
  logic [7:0] rx_q[$];
  int         checks = 0;
  int         errors = 0;
  int         mem_delay = 0;
  int         mcnt;
  logic [7:0] rx_b;
  logic       prev_busy = 1'b0;
  logic       prev_stb = 1'b0;
  logic       prev_ack = 1'b0;
  logic [67:0] prev_bus;

  always #5 sys_clk = ~sys_clk;

  uart_boot_loader #(
    .MAGIC      (8'hA5),
    .POLL_GAP   (4),
    .TIMEOUT_CYC(200),
    .MAX_LEN    (32'h10000)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .entry_o  (entry_o),
    .u_adr_o  (u_adr_o),
    .u_dat_o  (u_dat_o),
    .u_we_o   (u_we_o),
    .u_stb_o  (u_stb_o),
    .u_ack_i  (u_ack_i),
    .u_dat_i  (u_dat_i),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_sel_o  (m_sel_o),
    .m_we_o   (m_we_o),
    .m_stb_o  (m_stb_o),
    .m_ack_i  (m_ack_i)
  );

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART: combinational ack, RX data register loaded on the acked edge.
  assign u_ack_i = u_stb_o;
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      u_dat_i <= '0;
    end else if (u_stb_o && u_ack_i) begin
      if (rx_q.size() > 0) begin
        rx_b = rx_q.pop_front();
        u_dat_i <= {23'd0, 1'b1, rx_b};
      end else begin
        u_dat_i <= '0;
      end
    end
  end

  // Memory slave: single-cycle ack after mem_delay cycles of strobe.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_ack_i <= 1'b0;
      mcnt    <= 0;
    end else if (m_ack_i) begin
      m_ack_i <= 1'b0;
      mcnt    <= 0;
    end else if (m_stb_o) begin
      if (mcnt >= mem_delay) m_ack_i <= 1'b1;
      else mcnt <= mcnt + 1;
    end
  end

  // Write monitor.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prev_stb = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (m_stb_o) check("no poll during write", {191'd0, u_stb_o}, 192'd0);
      if (m_stb_o && prev_stb && !prev_ack)
        check("write held stable", {124'd0, m_adr_o, m_dat_o, m_sel_o}, {124'd0, prev_bus});
      if (m_stb_o && m_ack_i) begin
        if (exp_wr.size() == 0) begin
          check("unexpected write", {124'd0, m_adr_o, m_dat_o, m_sel_o}, 192'd0);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("write adr/dat/sel/we", {123'd0, m_adr_o, m_dat_o, m_sel_o, m_we_o},
                {123'd0, e.adr, e.dat, e.sel, 1'b1});
        end
      end
      prev_stb = m_stb_o;
      prev_ack = m_ack_i;
      prev_bus = {m_adr_o, m_dat_o, m_sel_o};
    end
  end

  // Completion monitor: result flags checked on busy falling.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (exp_end.size() == 0) begin
          check("unexpected completion", {155'd0, done, err, err_code, entry_o}, 192'd0);
        end else begin
          end_t e;
          e = exp_end.pop_front();
          check("done/err/code/entry", {155'd0, done, err, err_code, entry_o},
                {155'd0, e.ok, !e.ok, e.ok ? 2'd0 : e.code, e.entry});
        end
      end
      prev_busy = busy;
    end
  end

  function automatic logic [191:0] all_outputs();
    return {19'd0, busy, done, err, err_code, entry_o, u_stb_o, u_we_o, u_adr_o, u_dat_o,
            m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o};
  endfunction

  task automatic run_load(input int delay);
    int n;
    mem_delay = delay;
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 4000) begin
      @(negedge sys_clk);
      n++;
    end
    check("load completes", {191'd0, busy}, 192'd0);
    repeat (3) @(negedge sys_clk);
  endtask

  initial begin
    int n;
    #1 check("reset outputs", all_outputs(), 192'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 1: two full words.
    rx_q = {8'hA5, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`ifdef BOOT_CHECKSUM_EN
    rx_q.push_back(8'h24);
`endif
    exp_wr.push_back('{32'h100, 32'h04030201, 4'hF});
    exp_wr.push_back('{32'h104, 32'h08070605, 4'hF});
    exp_end.push_back('{1'b1, 2'd0, 32'h100});
    run_load(0);

    // 2: partial last word.
    rx_q = {8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
`ifdef BOOT_CHECKSUM_EN
    rx_q.push_back(8'hFF);
`endif
    exp_wr.push_back('{32'h200, 32'h44332211, 4'hF});
    exp_wr.push_back('{32'h204, 32'h00000055, 4'h1});
    exp_end.push_back('{1'b1, 2'd0, 32'h200});
    run_load(0);

    // 3: bad magic.
    rx_q = {8'h5A};
    exp_end.push_back('{1'b0, 2'd1, 32'h200});
    run_load(0);

    // 4a: misaligned address; 4b: oversize length; 4c: RX stall.
    rx_q = {8'hA5, 8'h08, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01, 8'h00, 8'h00};
    exp_end.push_back('{1'b0, 2'd0, 32'h200});
    run_load(0);
    rx_q = {8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
    exp_end.push_back('{1'b0, 2'd0, 32'h200});
    run_load(0);
    rx_q = {8'hA5, 8'h04};
    exp_end.push_back('{1'b0, 2'd2, 32'h200});
    run_load(0);

    // 5: slow memory ack.
    rx_q = {8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
`ifdef BOOT_CHECKSUM_EN
    rx_q.push_back(8'hFF);
`endif
    exp_wr.push_back('{32'h300, 32'h44332211, 4'hF});
    exp_wr.push_back('{32'h304, 32'h00000055, 4'h1});
    exp_end.push_back('{1'b1, 2'd0, 32'h300});
    run_load(10);

`ifdef BOOT_CHECKSUM_EN
    // 6: wrong checksum leaves entry unchanged.
    rx_q = {8'hA5, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h25};
    exp_wr.push_back('{32'h100, 32'h04030201, 4'hF});
    exp_wr.push_back('{32'h104, 32'h08070605, 4'hF});
    exp_end.push_back('{1'b0, 2'd3, 32'h300});
    run_load(0);
`endif

    // 7: reset while the first write is pending.
    rx_q = {8'hA5, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00,
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    mem_delay = 40;
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    n = 0;
    while (!m_stb_o && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    check("write pending before reset", {191'd0, m_stb_o}, {191'd0, 1'b1});
    #2 sys_rst_n = 1'b0;
    #1 check("outputs in mid-load reset", all_outputs(), 192'd0);
    repeat (2) @(negedge sys_clk);
    rx_q.delete();
    mem_delay = 0;
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 1 again after reset.
    rx_q = {8'hA5, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`ifdef BOOT_CHECKSUM_EN
    rx_q.push_back(8'h24);
`endif
    exp_wr.push_back('{32'h100, 32'h04030201, 4'hF});
    exp_wr.push_back('{32'h104, 32'h08070605, 4'hF});
    exp_end.push_back('{1'b1, 2'd0, 32'h100});
    run_load(0);

    repeat (5) @(negedge sys_clk);
    check("writes outstanding", 192'(exp_wr.size()), 192'd0);
    check("completions outstanding", 192'(exp_end.size()), 192'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
